// File: rtl/imgcrop_roi.sv
// rtl/imgcrop_roi.sv - AXI4-Stream video region-of-interest cropper
module imgcrop_roi #(
    parameter int unsigned DATA_WIDTH    = 24,
    parameter int unsigned IMG_WIDTH     = 640,
    parameter int unsigned IMG_HEIGHT    = 416,
    parameter int unsigned DEF_ROW_START = 0,
    parameter int unsigned DEF_ROW_END   = 416,
    parameter int unsigned DEF_COL_START = 0,
    parameter int unsigned DEF_COL_END   = 640,
    localparam int unsigned CW = $clog2(IMG_WIDTH + 1),
    localparam int unsigned RW = $clog2(IMG_HEIGHT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_video_tdata,
    input  logic                  s_axis_video_tvalid,
    input  logic                  s_axis_video_tlast,
    input  logic                  s_axis_video_tuser,
    output logic                  s_axis_video_tready,
    output logic [DATA_WIDTH-1:0] m_axis_video_tdata,
    output logic                  m_axis_video_tvalid,
    output logic                  m_axis_video_tlast,
    output logic                  m_axis_video_tuser,
    input  logic                  m_axis_video_tready,
    input  logic [RW-1:0]         cfg_row_start,
    input  logic [RW-1:0]         cfg_row_end,
    input  logic [CW-1:0]         cfg_col_start,
    input  logic [CW-1:0]         cfg_col_end,
    input  logic                  cfg_bypass,
    output logic                  err_eol_early,
    output logic                  err_eol_late
);

    // Position of the next accepted beat
    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;

    // ROI bounds in force for the current frame
    logic [RW-1:0] act_row_start, act_row_end;
    logic [CW-1:0] act_col_start, act_col_end;
    logic          act_bypass;

    // Position and bounds that apply to the beat on the input bus right now
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic [RW-1:0] eff_row_start, eff_row_end;
    logic [CW-1:0] eff_col_start, eff_col_end;
    logic          eff_bypass;
    logic          in_roi;
    logic          accept;
    logic          load;
    logic          out_user;
    logic          out_last;
    logic [CW-1:0] next_col;
    logic [RW-1:0] next_row;

    // A tuser beat restarts the position and is judged with the freshly sampled config
    always_comb begin
        cur_col       = s_axis_video_tuser ? '0 : col_cnt;
        cur_row       = s_axis_video_tuser ? '0 : row_cnt;
        eff_row_start = s_axis_video_tuser ? cfg_row_start : act_row_start;
        eff_row_end   = s_axis_video_tuser ? cfg_row_end   : act_row_end;
        eff_col_start = s_axis_video_tuser ? cfg_col_start : act_col_start;
        eff_col_end   = s_axis_video_tuser ? cfg_col_end   : act_col_end;
        eff_bypass    = s_axis_video_tuser ? cfg_bypass    : act_bypass;

        in_roi = eff_bypass ||
                 ((cur_row >= eff_row_start) && (cur_row < eff_row_end) &&
                  (cur_col >= eff_col_start) && (cur_col < eff_col_end));

        // Dropped beats never wait for the output stage
        s_axis_video_tready = !m_axis_video_tvalid || m_axis_video_tready || !in_roi;
        accept = s_axis_video_tvalid && s_axis_video_tready;
        load   = accept && in_roi;

        out_user = eff_bypass ? s_axis_video_tuser
                              : ((cur_row == eff_row_start) && (cur_col == eff_col_start));
        out_last = eff_bypass ? s_axis_video_tlast
                              : ((cur_col == (eff_col_end - CW'(1))) || s_axis_video_tlast);

        next_col = (cur_col == CW'(IMG_WIDTH)) ? cur_col : cur_col + CW'(1);
        next_row = (cur_row == RW'(IMG_HEIGHT - 1)) ? '0 : cur_row + RW'(1);
    end

    // Position tracking, per-frame config latch and sticky line-length errors
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt       <= '0;
            row_cnt       <= '0;
            act_row_start <= RW'(DEF_ROW_START);
            act_row_end   <= RW'(DEF_ROW_END);
            act_col_start <= CW'(DEF_COL_START);
            act_col_end   <= CW'(DEF_COL_END);
            act_bypass    <= 1'b0;
            err_eol_early <= 1'b0;
            err_eol_late  <= 1'b0;
        end else if (accept) begin
            if (s_axis_video_tuser) begin
                act_row_start <= cfg_row_start;
                act_row_end   <= cfg_row_end;
                act_col_start <= cfg_col_start;
                act_col_end   <= cfg_col_end;
                act_bypass    <= cfg_bypass;
            end
            if (s_axis_video_tlast) begin
                col_cnt <= '0;
                row_cnt <= next_row;
            end else begin
                col_cnt <= next_col;
                row_cnt <= cur_row;
            end
            if (s_axis_video_tlast && (cur_col < CW'(IMG_WIDTH - 1)))
                err_eol_early <= 1'b1;
            if (cur_col == CW'(IMG_WIDTH))
                err_eol_late <= 1'b1;
        end
    end

    // Single output register: a new load wins over a drain in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_video_tvalid <= 1'b0;
            m_axis_video_tdata  <= '0;
            m_axis_video_tuser  <= 1'b0;
            m_axis_video_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_video_tvalid <= 1'b1;
            m_axis_video_tdata  <= s_axis_video_tdata;
            m_axis_video_tuser  <= out_user;
            m_axis_video_tlast  <= out_last;
        end else if (m_axis_video_tready) begin
            m_axis_video_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imgcrop_roi.sv
// tb/tb_imgcrop_roi.sv - randomized bench for imgcrop_roi against a frame-level model
module tb_imgcrop_roi;
    localparam int DW = 24;
    localparam int W  = 16;
    localparam int H  = 8;
    localparam int CW = $clog2(W + 1);
    localparam int RW = $clog2(H + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid, m_tlast, m_tuser;
    logic          m_tready = 1'b1;
    logic [RW-1:0] cfg_row_start = '0, cfg_row_end = RW'(H);
    logic [CW-1:0] cfg_col_start = '0, cfg_col_end = CW'(W);
    logic          cfg_bypass = 1'b0;
    logic          err_eol_early, err_eol_late;

    imgcrop_roi #(
        .DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H),
        .DEF_ROW_START(0), .DEF_ROW_END(H), .DEF_COL_START(0), .DEF_COL_END(W)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_video_tdata(s_tdata), .s_axis_video_tvalid(s_tvalid),
        .s_axis_video_tlast(s_tlast), .s_axis_video_tuser(s_tuser),
        .s_axis_video_tready(s_tready),
        .m_axis_video_tdata(m_tdata), .m_axis_video_tvalid(m_tvalid),
        .m_axis_video_tlast(m_tlast), .m_axis_video_tuser(m_tuser),
        .m_axis_video_tready(m_tready),
        .cfg_row_start(cfg_row_start), .cfg_row_end(cfg_row_end),
        .cfg_col_start(cfg_col_start), .cfg_col_end(cfg_col_end),
        .cfg_bypass(cfg_bypass),
        .err_eol_early(err_eol_early), .err_eol_late(err_eol_late)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int n_out = 0;
    int rmode = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;
    beat_t exp_q[$];

    // Reference model state: where the next beat lands, the frame's ROI, error flags
    int mrow = 0, mcol = 0;
    int a_rs = 0, a_re = H, a_cs = 0, a_ce = W;
    bit a_byp = 0;
    bit e_early = 0, e_late = 0;

    bit            lat_pend = 0;
    logic [DW-1:0] lat_d;
    bit            prev_stall = 0;
    logic [DW+1:0] prev_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic bit model_in_roi(input bit u);
        int r, c, rs, re, cs, ce;
        bit b;
        if (u) begin
            r = 0; c = 0;
            rs = int'(cfg_row_start); re = int'(cfg_row_end);
            cs = int'(cfg_col_start); ce = int'(cfg_col_end);
            b = cfg_bypass;
        end else begin
            r = mrow; c = mcol;
            rs = a_rs; re = a_re; cs = a_cs; ce = a_ce;
            b = a_byp;
        end
        return b || (r >= rs && r < re && c >= cs && c < ce);
    endfunction

    task automatic model_accept(input logic [DW-1:0] d, input bit u, input bit l, output bit pushed);
        int r, c;
        beat_t bt;
        pushed = model_in_roi(u);
        if (u) begin
            a_rs = int'(cfg_row_start); a_re = int'(cfg_row_end);
            a_cs = int'(cfg_col_start); a_ce = int'(cfg_col_end);
            a_byp = cfg_bypass;
            r = 0; c = 0;
        end else begin
            r = mrow; c = mcol;
        end
        if (pushed) begin
            bt.d = d;
            bt.u = a_byp ? u : (r == a_rs && c == a_cs);
            bt.l = a_byp ? l : (l || c == a_ce - 1);
            exp_q.push_back(bt);
        end
        if (l && c < W - 1) e_early = 1;
        if (c == W) e_late = 1;
        if (l) begin
            mcol = 0;
            mrow = (r + 1) % H;
        end else begin
            mcol = (c + 1 > W) ? W : c + 1;
            mrow = r;
        end
    endtask

    task automatic model_reset();
        mrow = 0; mcol = 0;
        a_rs = 0; a_re = H; a_cs = 0; a_ce = W; a_byp = 0;
        e_early = 0; e_late = 0;
        exp_q.delete();
        lat_pend = 0;
        prev_stall = 0;
    endtask

    // Downstream ready pattern: 0 always, 1 toggling, 2 random, 3 held low
    always @(posedge clk) begin
        #1;
        case (rmode)
            0: m_tready = 1'b1;
            1: m_tready = ~m_tready;
            2: m_tready = 1'($urandom_range(1));
            default: m_tready = 1'b0;
        endcase
    end

    // Output monitor: ordered compare, one-cycle latency and stall stability
    always @(negedge clk) begin
        if (!rst) begin
            if (lat_pend) begin
                chk("latency_valid", 32'(m_tvalid), 32'd1);
                chk("latency_data", 32'(m_tdata), 32'(lat_d));
                lat_pend = 0;
            end
            if (prev_stall)
                chk("stall_hold", 32'({m_tdata, m_tuser, m_tlast}), 32'(prev_out));
            if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(m_tdata), 32'hFFFF_FFFF);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("out_beat", 32'({m_tdata, m_tuser, m_tlast}), 32'({e.d, e.u, e.l}));
                end
                n_out++;
            end
            prev_stall = (m_tvalid === 1'b1) && (m_tready === 1'b0);
            prev_out   = {m_tdata, m_tuser, m_tlast};
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input bit u, input bit l);
        bit got = 0;
        bit rdy;
        bit pushed;
        if ($urandom_range(3) == 0) begin
            s_tvalid = 1'b0;
            @(posedge clk); #1;
        end
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            rdy = s_tready;
            if (!model_in_roi(u))
                chk("tready_out_of_roi", 32'(s_tready), 32'd1);
            @(posedge clk); #1;
            got = rdy;
        end
        s_tvalid = 1'b0;
        if (!got) begin
            chk("accept_timeout", 32'd0, 32'd1);
        end else begin
            model_accept(d, u, l, pushed);
            if (pushed) begin
                lat_pend = 1;
                lat_d = d;
            end
        end
    endtask

    task automatic send_line(input int len, input bit sof);
        for (int c = 0; c < len; c++)
            send_beat(DW'($urandom()), sof && c == 0, c == len - 1);
    endtask

    task automatic send_frame();
        for (int r = 0; r < H; r++)
            send_line(W, r == 0);
    endtask

    task automatic set_cfg(input int rs, input int re, input int cs, input int ce, input bit b);
        cfg_row_start = RW'(rs); cfg_row_end = RW'(re);
        cfg_col_start = CW'(cs); cfg_col_end = CW'(ce);
        cfg_bypass = b;
    endtask

    task automatic drain(input string tag, input int exp_cnt);
        for (int k = 0; k < 400 && exp_q.size() != 0; k++)
            @(posedge clk);
        @(posedge clk); #1;
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_valid_idle"}, 32'(m_tvalid), 32'd0);
        chk({tag, "_count"}, 32'(n_out), 32'(exp_cnt));
        n_out = 0;
    endtask

    initial begin
        #2;
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_bus", 32'({m_tdata, m_tuser, m_tlast}), 32'd0);
        chk("rst_errors", 32'({err_eol_early, err_eol_late}), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        rmode = 0; n_out = 0;
        send_frame();
        drain("default_frame", W * H);

        set_cfg(4, 8, 3, 13, 0);
        send_frame();
        drain("roi_frame", 40);

        rmode = 1;
        send_frame();
        drain("roi_toggle", 40);

        rmode = 2;
        for (int r = 0; r < H; r++) begin
            if (r == 3) set_cfg(1, 3, 0, 5, 0);
            send_line(W, r == 0);
        end
        drain("cfg_midframe", 40);
        send_frame();
        drain("cfg_next_frame", 10);

        set_cfg(0, H, 0, W, 1);
        send_frame();
        drain("bypass", W * H);

        set_cfg(5, 5, 0, W, 0);
        send_frame();
        drain("empty_roi", 0);

        set_cfg(0, H, 0, W, 0);
        rmode = 0;
        for (int r = 0; r < H; r++)
            send_line((r == 5) ? 7 : (r == 6) ? 18 : W, r == 0);
        drain("bad_lines", 119);
        chk("err_early_set", 32'(err_eol_early), 32'(e_early));
        chk("err_late_set", 32'(err_eol_late), 32'(e_late));
        rmode = 2;
        send_frame();
        drain("realign", W * H);
        chk("err_sticky", 32'({err_eol_early, err_eol_late}), 32'b11);

        send_line(1, 1);
        for (int r = 1; r < H; r++)
            send_line(W, 0);
        drain("one_pixel_line", 113);

        rmode = 3;
        @(posedge clk); #1;
        send_beat(DW'($urandom()), 1, 0);
        s_tdata = DW'($urandom()); s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b1;
        @(negedge clk);
        chk("stall_in_roi", 32'(s_tready), 32'd0);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(m_tvalid), 32'd0);
        chk("async_rst_bus", 32'({m_tdata, m_tuser, m_tlast}), 32'd0);
        chk("async_rst_errors", 32'({err_eol_early, err_eol_late}), 32'd0);
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        model_reset();
        n_out = 0;
        rst = 1'b0;
        rmode = 0;
        set_cfg(4, 8, 3, 13, 0);
        send_frame();
        drain("after_reset", 40);
        chk("final_errors", 32'({err_eol_early, err_eol_late}), 32'({e_early, e_late}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
